mod_recombine: RTL and testbench

Sequential inverse of the datapath modulo component. Given a quotient `q`, divisor `b` and remainder `r`, it reconstructs the dividend `a = q*b + r` using an iterative shift-add multiplier followed by a final add. It sits downstream of the divide/modulo components in the datapath library and is used for checking and reconstructing operands. It uses a start/done handshake, so a multiply costs no combinational multiplier area.

---
 rtl/mod_recombine_pkg.sv | 16 +
 rtl/mod_recombine_if.sv | 24 ++
 rtl/mod_recombine_mul.sv | 49 ++++
 rtl/mod_recombine.sv | 106 ++++++++++
 tb/tb_mod_recombine.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mod_recombine_pkg.sv
// Shared types and sizing helpers for the modulo-recombine datapath.
package mod_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Counter must hold values 0..w inclusive.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mod_recombine_if.sv
// Start/done handshake bundle between a requester and mod_recombine.
interface mod_recombine_if #(
    parameter int unsigned DATAWIDTH = 2
);
    logic                 start;
    logic [DATAWIDTH-1:0] q;
    logic [DATAWIDTH-1:0] b;
    logic [DATAWIDTH-1:0] r;
    logic                 busy;
    logic                 done;
    logic [DATAWIDTH-1:0] a;
    logic                 ovf;
    logic                 err;

    modport master (
        output start, q, b, r,
        input  busy, done, a, ovf, err
    );

    modport slave (
        input  start, q, b, r,
        output busy, done, a, ovf, err
    );
endinterface

// File: rtl/mod_recombine_mul.sv
// Iterative shift-add multiplier: one partial product per step, full-width product.
module shift_add_mul
    import mod_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic                   step,
    input  logic [DATAWIDTH-1:0]   q,
    input  logic [DATAWIDTH-1:0]   b,
    output logic [2*DATAWIDTH-1:0] acc,
    output logic                   last
);

    localparam int unsigned CW = cnt_width(DATAWIDTH);
    localparam int unsigned AW = 2 * DATAWIDTH;

    logic [DATAWIDTH-1:0] q_sh;
    logic [AW-1:0]        b_ext;
    logic [AW-1:0]        acc_q;
    logic [CW-1:0]        cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_sh  <= '0;
            b_ext <= '0;
            acc_q <= '0;
            cnt   <= '0;
        end else if (load) begin
            q_sh  <= q;
            b_ext <= AW'(b);
            acc_q <= '0;
            cnt   <= '0;
        end else if (step) begin
            if (q_sh[0]) begin
                acc_q <= acc_q + (b_ext << cnt);
            end
            q_sh <= q_sh >> 1;
            cnt  <= cnt + CW'(1);
        end
    end

    // Asserted during the final iteration so the FSM can leave MUL on that edge.
    assign last = (cnt == CW'(DATAWIDTH - 1));
    assign acc  = acc_q;

endmodule

// File: rtl/mod_recombine.sv
// Reconstructs a = q*b + r over a start/done handshake with fixed DATAWIDTH+2 latency.
// Optional remainder range check enabled by defining MOD_RECOMBINE_CHECK_EN.
module mod_recombine
    import mod_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 2
) (
    input  logic            Clk,
    input  logic            Rst,
    mod_recombine_if.slave  bus
);

    localparam int unsigned AW = 2 * DATAWIDTH;
    localparam int unsigned SW = AW + 1;

    state_t               state;
    logic [DATAWIDTH-1:0] r_lat;
`ifdef MOD_RECOMBINE_CHECK_EN
    logic [DATAWIDTH-1:0] b_lat;
`endif
    logic [SW-1:0]        sum;
    logic [DATAWIDTH-1:0] a_q;
    logic                 ovf_q;
    logic                 err_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 load_c;
    logic                 step_c;
    logic                 last;
    logic [AW-1:0]        acc;

    assign load_c = (state == IDLE) && bus.start;
    assign step_c = (state == MUL);

    shift_add_mul #(.DATAWIDTH(DATAWIDTH)) u_mul (
        .clk   (Clk),
        .rst_n (Rst),
        .load  (load_c),
        .step  (step_c),
        .q     (bus.q),
        .b     (bus.b),
        .acc   (acc),
        .last  (last)
    );

    // Control FSM; final add and result flags are registered here.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state  <= IDLE;
            r_lat  <= '0;
`ifdef MOD_RECOMBINE_CHECK_EN
            b_lat  <= '0;
`endif
            sum    <= '0;
            a_q    <= '0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        r_lat  <= bus.r;
`ifdef MOD_RECOMBINE_CHECK_EN
                        b_lat  <= bus.b;
`endif
                        busy_q <= 1'b1;
                        state  <= MUL;
                    end
                end
                MUL: begin
                    if (last) begin
                        state <= ADD;
                    end
                end
                ADD: begin
                    sum   <= SW'(acc) + SW'(r_lat);
                    state <= DONE;
                end
                DONE: begin
                    a_q    <= sum[DATAWIDTH-1:0];
                    ovf_q  <= |sum[SW-1:DATAWIDTH];
`ifdef MOD_RECOMBINE_CHECK_EN
                    err_q  <= (r_lat >= b_lat);
`else
                    err_q  <= 1'b0;
`endif
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.a    = a_q;
    assign bus.ovf  = ovf_q;
    assign bus.err  = err_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_mod_recombine.sv
// Directed self-checking bench for mod_recombine at DATAWIDTH=8.
module tb_mod_recombine;

    localparam int unsigned W = 8;
`ifdef MOD_RECOMBINE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    mod_recombine_if #(.DATAWIDTH(W)) bus ();

    mod_recombine #(.DATAWIDTH(W)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    // Launch one operation and wait (bounded) for done; lat = -1 on timeout.
    task automatic run_op(input logic [W-1:0] qi, input logic [W-1:0] bi, input logic [W-1:0] ri,
                          output int lat, output logic [W-1:0] ao, output logic ovo, output logic ero);
        lat = -1;
        bus.start = 1'b1; bus.q = qi; bus.b = bi; bus.r = ri;
        @(posedge Clk); #1;
        bus.start = 1'b0;
        bus.q = W'($urandom); bus.b = W'($urandom); bus.r = W'($urandom);
        for (int n = 1; n <= 20; n++) begin
            @(posedge Clk); #1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        ao = bus.a; ovo = bus.ovf; ero = bus.err;
    endtask

    task automatic test_reset();
        Rst = 1'b0; bus.start = 1'b0; bus.q = '0; bus.b = '0; bus.r = '0;
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.a, bus.ovf, bus.err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b a=%0d ovf=%b err=%b want all 0",
                     bus.busy, bus.done, bus.a, bus.ovf, bus.err);
        end
        @(negedge Clk); Rst = 1'b1;
        @(posedge Clk); #1;
    endtask

    task automatic test_basic();
        int lat; logic [W-1:0] a; logic o, e;
        bus.start = 1'b1; bus.q = 8'd5; bus.b = 8'd7; bus.r = 8'd3;
        @(posedge Clk); #1;
        bus.start = 1'b0; bus.q = 8'hAA; bus.b = 8'h55; bus.r = 8'h33;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL basic_busy_after_accept got %b want 1", bus.busy);
        end
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge Clk); #1;
            if (bus.done) begin lat = n; break; end
        end
        a = bus.a; o = bus.ovf; e = bus.err;
        checks++;
        if (lat != 10) begin errors++; $display("FAIL basic_latency got %0d want 10", lat); end
        checks++;
        if (a !== 8'd38) begin errors++; $display("FAIL basic_a got %0d want 38", a); end
        checks++;
        if ({o, e} !== 2'b00) begin errors++; $display("FAIL basic_flags got ovf=%b err=%b want 0 0", o, e); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b want 0", bus.busy); end
        @(posedge Clk); #1;
        checks++;
        if ({bus.done, bus.a} !== {1'b0, 8'd38}) begin
            errors++; $display("FAIL basic_hold got done=%b a=%0d want done=0 a=38", bus.done, bus.a);
        end
    endtask

    task automatic test_overflow();
        int lat; logic [W-1:0] a; logic o, e;
        run_op(8'hFF, 8'h02, 8'h01, lat, a, o, e);
        checks++;
        if (lat != 10) begin errors++; $display("FAIL ovf_latency got %0d want 10", lat); end
        checks++;
        if ({a, o, e} !== {8'hFF, 1'b1, 1'b0}) begin
            errors++; $display("FAIL ovf_result got a=%h ovf=%b err=%b want a=ff ovf=1 err=0", a, o, e);
        end
    endtask

    task automatic test_err_range();
        int lat; logic [W-1:0] a; logic o, e;
        run_op(8'd4, 8'd7, 8'd7, lat, a, o, e);
        checks++;
        if ({a, o, e} !== {8'd35, 1'b0, CHK}) begin
            errors++; $display("FAIL err_eq got a=%0d ovf=%b err=%b want a=35 ovf=0 err=%b", a, o, e, CHK);
        end
    endtask

    task automatic test_b_zero();
        int lat; logic [W-1:0] a; logic o, e;
        run_op(8'd9, 8'd0, 8'd0, lat, a, o, e);
        checks++;
        if ({a, o, e} !== {8'd0, 1'b0, CHK}) begin
            errors++; $display("FAIL bzero_r0 got a=%0d ovf=%b err=%b want a=0 ovf=0 err=%b", a, o, e, CHK);
        end
        run_op(8'd3, 8'd0, 8'd5, lat, a, o, e);
        checks++;
        if ({a, o, e} !== {8'd5, 1'b0, CHK}) begin
            errors++; $display("FAIL bzero_r5 got a=%0d ovf=%b err=%b want a=5 ovf=0 err=%b", a, o, e, CHK);
        end
        checks++;
        if (lat != 10) begin errors++; $display("FAIL bzero_latency got %0d want 10", lat); end
    endtask

    task automatic test_max();
        int lat; logic [W-1:0] a; logic o, e;
        // 255*255+255 = 0xFF00: low byte 0, upper bits set.
        run_op(8'hFF, 8'hFF, 8'hFF, lat, a, o, e);
        checks++;
        if ({a, o, e} !== {8'h00, 1'b1, CHK}) begin
            errors++; $display("FAIL max_result got a=%h ovf=%b err=%b want a=00 ovf=1 err=%b", a, o, e, CHK);
        end
        checks++;
        if (lat != 10) begin errors++; $display("FAIL max_latency got %0d want 10", lat); end
    endtask

    task automatic test_ignored_start();
        int dones = 0;
        logic [W-1:0] a_seen = '0;
        bus.start = 1'b1; bus.q = 8'd6; bus.b = 8'd5; bus.r = 8'd2;
        @(posedge Clk); #1;
        bus.start = 1'b0;
        for (int n = 1; n <= 24; n++) begin
            if (n == 3) begin
                bus.start = 1'b1; bus.q = 8'd1; bus.b = 8'd1; bus.r = 8'd1;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge Clk); #1;
            if (bus.done) begin dones++; a_seen = bus.a; end
        end
        checks++;
        if (dones != 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", dones); end
        checks++;
        if (a_seen !== 8'd32) begin errors++; $display("FAIL ignore_result got %0d want 32", a_seen); end
        checks++;
        if (bus.a !== 8'd32) begin errors++; $display("FAIL ignore_hold got %0d want 32", bus.a); end
    endtask

    task automatic test_back_to_back();
        int d[$];
        bus.start = 1'b1; bus.q = 8'd1; bus.b = 8'd1; bus.r = 8'd0;
        for (int k = 0; k <= 33; k++) begin
            @(posedge Clk); #1;
            if (bus.done) d.push_back(k);
        end
        bus.start = 1'b0;
        checks++;
        if (d.size() != 3) begin
            errors++; $display("FAIL b2b_done_count got %0d want 3", d.size());
        end else begin
            checks++;
            if (d[0] != 10 || d[1] - d[0] != 11 || d[2] - d[1] != 11) begin
                errors++; $display("FAIL b2b_spacing got %0d %0d %0d want 10 21 32", d[0], d[1], d[2]);
            end
        end
        repeat (15) @(posedge Clk);
        #1;
        checks++;
        if ({bus.busy, bus.a} !== {1'b0, 8'd1}) begin
            errors++; $display("FAIL b2b_drain got busy=%b a=%0d want busy=0 a=1", bus.busy, bus.a);
        end
    endtask

    task automatic test_reset_mid();
        int lat; int dones = 0; logic [W-1:0] a; logic o, e;
        bus.start = 1'b1; bus.q = 8'd5; bus.b = 8'd7; bus.r = 8'd3;
        @(posedge Clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge Clk);
        #3 Rst = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.a, bus.ovf, bus.err} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got busy=%b done=%b a=%0d want 0 0 0", bus.busy, bus.done, bus.a);
        end
        @(negedge Clk); @(negedge Clk); Rst = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(posedge Clk); #1;
            if (bus.done) dones++;
        end
        checks++;
        if (dones != 0) begin errors++; $display("FAIL midreset_spurious_done got %0d want 0", dones); end
        run_op(8'd2, 8'd3, 8'd1, lat, a, o, e);
        checks++;
        if ({a, o, e} !== {8'd7, 1'b0, 1'b0} || lat != 10) begin
            errors++; $display("FAIL midreset_recover got a=%0d ovf=%b err=%b lat=%0d want 7 0 0 10", a, o, e, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_err_range();
        test_b_zero();
        test_max();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
